// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Data-bus interface between the load/store unit (master)
//                and the data memory / bus fabric (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I memory-access stage. One data-bus transaction per
//                request, byte-lane steering for stores, sign/zero extension
//                for loads, misalignment / illegal-funct3 / timeout errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        is_store,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] store_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      load_data,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t              r_state_q,     w_state_d;
    logic [2:0]          r_funct3_q,    w_funct3_d;
    logic [1:0]          r_lsb_q,       w_lsb_d;
    logic [c_CNT_W-1:0]  r_cnt_q,       w_cnt_d;
    logic                r_err_q,       w_err_d;
    logic [31:0]         r_load_q,      w_load_d;
    logic                r_req_q,       w_req_d;
    logic                r_we_q,        w_we_d;
    logic [31:0]         r_addr_q,      w_addr_d;
    logic [3:0]          r_wstrb_q,     w_wstrb_d;
    logic [31:0]         r_wdata_q,     w_wdata_d;

    logic                w_legal;
    logic                w_aligned;
    logic                w_timeout;

    // Extract the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] f_extend(input logic [31:0] rdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lsb);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(rdata >> {lsb, 3'b000});
        h = lsb[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Decode legality and alignment of the incoming request.
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        if (is_store)
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        case (funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt_q == c_CNT_LAST);

    // Next-state and next-register logic for the IDLE/REQ/RESP sequencer.
    always_comb begin
        w_state_d  = r_state_q;
        w_funct3_d = r_funct3_q;
        w_lsb_d    = r_lsb_q;
        w_cnt_d    = r_cnt_q;
        w_err_d    = r_err_q;
        w_load_d   = r_load_q;
        w_req_d    = r_req_q;
        w_we_d     = r_we_q;
        w_addr_d   = r_addr_q;
        w_wstrb_d  = r_wstrb_q;
        w_wdata_d  = r_wdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_funct3_d = funct3;
                    w_lsb_d    = addr[1:0];
                    if (w_legal && w_aligned) begin
                        w_state_d = S_REQ;
                        w_cnt_d   = '0;
                        w_req_d   = 1'b1;
                        w_we_d    = is_store;
                        w_addr_d  = {addr[31:2], 2'b00};
                        w_wstrb_d = 4'b0000;
                        if (is_store) begin
                            case (funct3[1:0])
                                2'b00: begin
                                    w_wstrb_d = 4'b0001 << addr[1:0];
                                    w_wdata_d = {4{store_data[7:0]}};
                                end
                                2'b01: begin
                                    w_wstrb_d = 4'b0011 << addr[1:0];
                                    w_wdata_d = {2{store_data[15:0]}};
                                end
                                default: begin
                                    w_wstrb_d = 4'b1111;
                                    w_wdata_d = store_data;
                                end
                            endcase
                        end
                    end else begin
                        // Rejected request: report at once, bus untouched.
                        w_state_d = S_RESP;
                        w_err_d   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    w_state_d = S_RESP;
                    w_req_d   = 1'b0;
                    w_err_d   = 1'b0;
                    if (!r_we_q)
                        w_load_d = f_extend(bus.mem_rdata, r_funct3_q, r_lsb_q);
                end else if (w_timeout) begin
                    w_state_d = S_RESP;
                    w_req_d   = 1'b0;
                    w_err_d   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_req_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_funct3_q <= 3'b000;
            r_lsb_q    <= 2'b00;
            r_cnt_q    <= '0;
            r_err_q    <= 1'b0;
            r_load_q   <= 32'd0;
            r_req_q    <= 1'b0;
            r_we_q     <= 1'b0;
            r_addr_q   <= 32'd0;
            r_wstrb_q  <= 4'b0000;
            r_wdata_q  <= 32'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_funct3_q <= w_funct3_d;
            r_lsb_q    <= w_lsb_d;
            r_cnt_q    <= w_cnt_d;
            r_err_q    <= w_err_d;
            r_load_q   <= w_load_d;
            r_req_q    <= w_req_d;
            r_we_q     <= w_we_d;
            r_addr_q   <= w_addr_d;
            r_wstrb_q  <= w_wstrb_d;
            r_wdata_q  <= w_wdata_d;
        end
    end

    assign busy          = (r_state_q != S_IDLE);
    assign done          = (r_state_q == S_RESP);
    assign err           = r_err_q;
    assign load_data     = r_load_q;
    assign bus.mem_req   = r_req_q;
    assign bus.mem_we    = r_we_q;
    assign bus.mem_addr  = r_addr_q;
    assign bus.mem_wstrb = r_wstrb_q;
    assign bus.mem_wdata = r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    int n_checks;
    int n_fail;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .bus        (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns in the cycle after that edge.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Zero-wait load; returns in the done cycle.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        issue(1'b0, f3, a, 32'd0);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = rd;
        step();
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'd0; store_data = 32'd0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;
        step();
        step();

        // Reset state
        chk("rst busy",  busy, 1'b0);
        chk("rst done",  done, 1'b0);
        chk("rst err",   err,  1'b0);
        chk("rst req",   bus_if.mem_req, 1'b0);
        chk("rst we",    bus_if.mem_we,  1'b0);
        chk("rst wstrb", bus_if.mem_wstrb, 4'b0000);
        chk("rst addr",  bus_if.mem_addr,  32'd0);
        chk("rst wdata", bus_if.mem_wdata, 32'd0);
        chk("rst load",  load_data, 32'd0);
        rst = 1'b0;
        step();

        // 1: LW, ready in first request cycle, done two cycles after start
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd0);
        chk("t1 req",   bus_if.mem_req, 1'b1);
        chk("t1 addr",  bus_if.mem_addr, 32'h0000_1000);
        chk("t1 we",    bus_if.mem_we, 1'b0);
        chk("t1 wstrb", bus_if.mem_wstrb, 4'b0000);
        chk("t1 busy",  busy, 1'b1);
        chk("t1 done early", done, 1'b0);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus_if.mem_ready = 1'b0;
        chk("t1 done", done, 1'b1);
        chk("t1 err",  err, 1'b0);
        chk("t1 load", load_data, 32'hDEAD_BEEF);
        chk("t1 req off", bus_if.mem_req, 1'b0);
        step();
        chk("t1 done pulse", done, 1'b0);
        chk("t1 idle", busy, 1'b0);
        chk("t1 hold", load_data, 32'hDEAD_BEEF);

        // 2: byte/half extraction and extension
        do_load(3'b000, 32'h0000_1003, 32'h80FF_FFFF);
        chk("t2 lb done", done, 1'b1);
        chk("t2 lb",  load_data, 32'hFFFF_FF80);
        step();
        do_load(3'b100, 32'h0000_1003, 32'h80FF_FFFF);
        chk("t2 lbu", load_data, 32'h0000_0080);
        step();
        do_load(3'b000, 32'h0000_1001, 32'h1122_7F44);
        chk("t2 lb lane1", load_data, 32'h0000_007F);
        step();
        do_load(3'b001, 32'h0000_1002, 32'h8001_1234);
        chk("t2 lh hi", load_data, 32'hFFFF_8001);
        step();
        do_load(3'b101, 32'h0000_1002, 32'h8001_1234);
        chk("t2 lhu hi", load_data, 32'h0000_8001);
        step();
        do_load(3'b101, 32'h0000_1000, 32'h0000_F00D);
        chk("t2 lhu lo", load_data, 32'h0000_F00D);
        step();

        // 3: stores, including a wait state with stable bus outputs
        issue(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
        chk("t3 sh req",   bus_if.mem_req, 1'b1);
        chk("t3 sh we",    bus_if.mem_we, 1'b1);
        chk("t3 sh wstrb", bus_if.mem_wstrb, 4'b1100);
        chk("t3 sh wdata", bus_if.mem_wdata, 32'hABCD_ABCD);
        chk("t3 sh addr",  bus_if.mem_addr, 32'h0000_2000);
        step();
        chk("t3 sh wait req",   bus_if.mem_req, 1'b1);
        chk("t3 sh wait wstrb", bus_if.mem_wstrb, 4'b1100);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h5555_5555;
        step();
        bus_if.mem_ready = 1'b0;
        chk("t3 sh done", done, 1'b1);
        chk("t3 sh err",  err, 1'b0);
        chk("t3 sh load untouched", load_data, 32'h0000_F00D);
        step();
        issue(1'b1, 3'b000, 32'h0000_3001, 32'hAABB_CC55);
        chk("t3 sb wstrb", bus_if.mem_wstrb, 4'b0010);
        chk("t3 sb wdata", bus_if.mem_wdata, 32'h5555_5555);
        bus_if.mem_ready = 1'b1;
        step();
        bus_if.mem_ready = 1'b0;
        step();
        issue(1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D);
        chk("t3 sw wstrb", bus_if.mem_wstrb, 4'b1111);
        chk("t3 sw wdata", bus_if.mem_wdata, 32'hCAFE_F00D);
        bus_if.mem_ready = 1'b1;
        step();
        bus_if.mem_ready = 1'b0;
        chk("t3 sw done", done, 1'b1);
        step();

        // 4: rejected requests finish one cycle after start, no bus activity
        issue(1'b0, 3'b010, 32'h0000_1001, 32'd0);
        chk("t4 lw mis done", done, 1'b1);
        chk("t4 lw mis err",  err, 1'b1);
        chk("t4 lw mis req",  bus_if.mem_req, 1'b0);
        chk("t4 lw mis addr", bus_if.mem_addr, 32'h0000_4000);
        chk("t4 lw mis load", load_data, 32'h0000_F00D);
        step();
        issue(1'b1, 3'b100, 32'h0000_0000, 32'd0);
        chk("t4 sw f3 done", done, 1'b1);
        chk("t4 sw f3 err",  err, 1'b1);
        chk("t4 sw f3 req",  bus_if.mem_req, 1'b0);
        step();
        issue(1'b0, 3'b001, 32'h0000_0001, 32'd0);
        chk("t4 lh mis err", {done, err, bus_if.mem_req}, 3'b110);
        step();
        issue(1'b0, 3'b011, 32'h0000_0000, 32'd0);
        chk("t4 ld f3 err", {done, err, bus_if.mem_req}, 3'b110);
        step();
        issue(1'b0, 3'b100, 32'h0000_0003, 32'd0);
        chk("t4 lbu ok", {bus_if.mem_req, busy, done}, 3'b110);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hFE00_0000;
        step();
        bus_if.mem_ready = 1'b0;
        chk("t4 lbu err clr", err, 1'b0);
        chk("t4 lbu data", load_data, 32'h0000_00FE);
        step();

        // 5: timeout after 16 request cycles
        issue(1'b0, 3'b001, 32'h0000_0000, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("t5 req/done", {bus_if.mem_req, done}, 2'b10);
            step();
        end
        chk("t5 done", done, 1'b1);
        chk("t5 err",  err, 1'b1);
        chk("t5 req",  bus_if.mem_req, 1'b0);
        chk("t5 load", load_data, 32'h0000_00FE);
        step();

        // mem_ready while idle is ignored
        bus_if.mem_ready = 1'b1;
        step();
        bus_if.mem_ready = 1'b0;
        chk("idle ready", {busy, done, bus_if.mem_req}, 3'b000);

        // 6: reset during request wait, then a normal transaction
        issue(1'b0, 3'b010, 32'h0000_5000, 32'd0);
        step();
        chk("t6 waiting", bus_if.mem_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6 rst busy", busy, 1'b0);
        chk("t6 rst req",  bus_if.mem_req, 1'b0);
        chk("t6 rst done", done, 1'b0);
        step();
        chk("t6 no done", done, 1'b0);
        do_load(3'b010, 32'h0000_5004, 32'h1357_9BDF);
        chk("t6 done", done, 1'b1);
        chk("t6 err",  err, 1'b0);
        chk("t6 load", load_data, 32'h1357_9BDF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
